stack_op_sequencer: RTL and testbench
=====================================

Name: stack_op_sequencer

Overview:
- Instruction sequencer that sits directly upstream of the stack/ALU integration stage.
- Accepts stack instructions over a valid/ready handshake.
- Expands each instruction into a cycle-by-cycle sequence of stackAction, in_val and aluCode.
- Captures the integration stage's top and aluResult outputs to write results back onto the stack, and tracks stack depth to flag overflow and underflow.

Parameters:
- DEPTH, 16, stack capacity in entries; the overflow limit.
- DW, 16, data width; matches in_val, top and aluResult.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  sequencer can accept an instruction this cycle.
- opcode  input  4  0 NOP, 1 PUSHI, 2 POP, 3 ALU, 4 DUP; any other value is illegal.
- imm  input  DW  PUSHI immediate; imm[2:0] is the ALU code for the ALU opcode.
- top  input  DW  top of stack, from the integration stage.
- alu_result  input  DW  aluResult, from the integration stage.
- in_val  output  DW  value to push.
- stack_action  output  4  0 NOP, 1 PUSH, 2 POP.
- alu_code  output  3  ALU code to the integration stage.
- depth  output  $clog2(DEPTH+1)  current stack occupancy.
- done  output  1  one-cycle pulse in the cycle an instruction's last action is driven.
- err  output  1  one-cycle pulse on a rejected instruction.
- err_code  output  2  1 underflow, 2 overflow, 3 illegal opcode; held until the next err.

Behaviour:
- Reset values:
  - All outputs 0 except instr_ready=1.
  - state=IDLE, internal result register 0.
- Handshake:
  - An instruction is accepted on a rising edge where instr_valid && instr_ready.
  - opcode and imm are sampled only at acceptance.
- Output timing: outputs are registered. The first action for an accepted instruction appears in the cycle after acceptance (cycle 1).
- The stack updates at the end of each cycle in which a non-NOP stack_action is driven; depth updates on the same edge.
- stack_action is NOP in every cycle not listed below.
- States:
  - IDLE.
  - ALU_CAP, ALU_POP1, ALU_POP2, ALU_PUSH.
  - DUP_CAP, DUP_PUSH.
- NOP: cycle 1 done=1. No stack action.
- PUSHI: cycle 1 stack_action=PUSH, in_val=imm, done=1. Requires depth<DEPTH.
- POP: cycle 1 stack_action=POP, done=1. Requires depth>=1.
- ALU (requires depth>=2):
  - alu_code<=imm[2:0] at acceptance and held until the next ALU acceptance.
  - ALU_CAP (cycle 1): result reg<=alu_result.
  - ALU_POP1 (cycle 2): POP.
  - ALU_POP2 (cycle 3): POP.
  - ALU_PUSH (cycle 4): PUSH with in_val=result reg, done=1.
  - Net depth change is -1.
- DUP (requires 1<=depth<DEPTH):
  - DUP_CAP (cycle 1): result reg<=top.
  - DUP_PUSH (cycle 2): PUSH with in_val=result reg, done=1.
- instr_ready:
  - Low from acceptance of a multi-cycle instruction until its final state.
  - High again during the final state (ALU_PUSH, DUP_PUSH), so the next instruction may be accepted in that cycle.
  - Single-cycle instructions keep instr_ready high, giving one instruction per cycle.
- Rejection:
  - Checked at acceptance against the depth value after any action completing in the same cycle.
  - No stack action is issued and depth is unchanged.
  - Cycle 1: err=1 with err_code set, done=0.
  - Priority is illegal > underflow > overflow.
- Boundaries:
  - depth saturates only via rejection and never exceeds DEPTH or goes below 0.
  - A PUSHI accepted during ALU_PUSH sees depth after the pending push is counted.
- Reset mid-sequence: state→IDLE, next cycle stack_action=NOP, depth=0.
  - rst must be applied to the stack and to this block together.

Optional Feature:
- Macro: STACK_SEQ_STICKY_ERR_EN.
- Defined:
  - The first err latches a halt flag.
  - instr_ready is held at 0 and no further instructions are accepted until rst.
  - err_code holds the first error.
- Undefined:
  - Errors are non-fatal one-cycle pulses.
  - instr_ready returns to 1 the cycle after the error.

Test Plan:
- Reset, then PUSHI 5 and PUSHI 7 back to back -> stack_action=PUSH in cycles 1 and 2 with in_val 5 then 7; depth=2; done pulses twice; instr_ready stays high.
- From depth=2 with top=7 and next=5, ALU imm=0 (add) with alu_result model 12 -> actions NOP, POP, POP, PUSH with in_val=12 at cycle 4; depth=1; done at cycle 4 only.
- POP at depth=0 -> err=1, err_code=1, stack_action=NOP, depth stays 0. ALU at depth=1 -> err_code=1.
- DEPTH=16 and 16 PUSHIs, then PUSHI and DUP -> both rejected with err_code=2, depth=16.
- opcode=9 -> err_code=3. With STACK_SEQ_STICKY_ERR_EN, instr_ready=0 until rst; without it, a following PUSHI 1 is accepted.
- Assert rst in ALU_POP1 -> next cycle state IDLE, stack_action=NOP, depth=0, instr_ready=1, done=0.

Source files
------------

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: expands stack instructions into per-cycle stack/ALU actions and tracks stack depth.
// Optional STACK_SEQ_STICKY_ERR_EN: the first rejected instruction halts acceptance until rst.
module stack_op_sequencer #(
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [3:0]                 opcode,
    input  logic [DW-1:0]              imm,
    input  logic [DW-1:0]              top,
    input  logic [DW-1:0]              alu_result,
    output logic [DW-1:0]              in_val,
    output logic [3:0]                 stack_action,
    output logic [2:0]                 alu_code,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code
);
    localparam int AW = $clog2(DEPTH + 1);
    localparam logic [3:0] OP_NOP = 4'd0, OP_PUSHI = 4'd1, OP_POP = 4'd2, OP_ALU = 4'd3, OP_DUP = 4'd4;
    localparam logic [3:0] ACT_NOP = 4'd0, ACT_PUSH = 4'd1, ACT_POP = 4'd2;
    localparam logic [1:0] E_NONE = 2'd0, E_UNDER = 2'd1, E_OVER = 2'd2, E_ILLEGAL = 2'd3;
    localparam logic [AW:0] ONE = (AW+1)'(1), TWO = (AW+1)'(2), FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ALU_CAP, ALU_POP1, ALU_POP2, ALU_PUSH, DUP_CAP, DUP_PUSH} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] res, res_nxt, in_val_nxt;
    logic [3:0]    action_nxt;
    logic [2:0]    alu_code_nxt;
    logic [AW:0]   eff_depth;
    logic [1:0]    rej_code, err_code_nxt;
    logic          accept, go, reject, halt_nxt, ready_nxt, done_nxt;

    // Depth as it will be once the action driven this cycle lands on the stack.
    assign eff_depth = {1'b0, depth} + (AW+1)'(stack_action == ACT_PUSH) - (AW+1)'(stack_action == ACT_POP);
    assign accept    = instr_valid && instr_ready;
    assign rej_code  = opcode > OP_DUP ? E_ILLEGAL
                     : (((opcode == OP_POP || opcode == OP_DUP) && eff_depth < ONE) ||
                        (opcode == OP_ALU && eff_depth < TWO)) ? E_UNDER
                     : ((opcode == OP_PUSHI || opcode == OP_DUP) && eff_depth >= FULL) ? E_OVER
                     : E_NONE;
    assign reject    = accept && rej_code != E_NONE;
    assign go        = accept && rej_code == E_NONE;

`ifdef STACK_SEQ_STICKY_ERR_EN
    logic halt;
    always_ff @(posedge clk) halt <= rst ? 1'b0 : halt | reject;
    assign halt_nxt = halt | reject;
`else
    assign halt_nxt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            res          <= '0;
            in_val       <= '0;
            stack_action <= ACT_NOP;
            alu_code     <= '0;
            depth        <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= E_NONE;
            instr_ready  <= 1'b1;
        end else begin
            state        <= state_nxt;
            res          <= res_nxt;
            in_val       <= in_val_nxt;
            stack_action <= action_nxt;
            alu_code     <= alu_code_nxt;
            depth        <= eff_depth[AW-1:0];
            done         <= done_nxt;
            err          <= reject;
            err_code     <= err_code_nxt;
            instr_ready  <= ready_nxt;
        end
    end

    // Final states (ALU_PUSH, DUP_PUSH) accept the next instruction like IDLE does.
    always_comb begin
        state_nxt = state;
        case (state)
            ALU_CAP:  state_nxt = ALU_POP1;
            ALU_POP1: state_nxt = ALU_POP2;
            ALU_POP2: state_nxt = ALU_PUSH;
            DUP_CAP:  state_nxt = DUP_PUSH;
            default:  state_nxt = !go ? IDLE : opcode == OP_ALU ? ALU_CAP : opcode == OP_DUP ? DUP_CAP : IDLE;
        endcase
    end

    always_comb begin
        res_nxt      = state == ALU_CAP ? alu_result : state == DUP_CAP ? top : res;
        action_nxt   = (state_nxt == ALU_POP1 || state_nxt == ALU_POP2) ? ACT_POP
                     : (state_nxt == ALU_PUSH || state_nxt == DUP_PUSH) ? ACT_PUSH
                     : (go && opcode == OP_PUSHI) ? ACT_PUSH
                     : (go && opcode == OP_POP) ? ACT_POP
                     : ACT_NOP;
        in_val_nxt   = (state_nxt == ALU_PUSH || state_nxt == DUP_PUSH) ? res_nxt
                     : (go && opcode == OP_PUSHI) ? imm
                     : in_val;
        done_nxt     = state_nxt == ALU_PUSH || state_nxt == DUP_PUSH || (go && opcode <= OP_POP);
        alu_code_nxt = (go && opcode == OP_ALU) ? imm[2:0] : alu_code;
        err_code_nxt = reject ? rej_code : err_code;
        ready_nxt    = !halt_nxt && (state_nxt == IDLE || state_nxt == ALU_PUSH || state_nxt == DUP_PUSH);
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed and randomized checks of stack_op_sequencer against a queue-based stack model.
module tb_stack_op_sequencer;
    localparam int DEPTH = 16, DW = 16, AW = $clog2(DEPTH + 1);

    logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic [DW-1:0] imm = '0, top = '0, alu_result = '0;
    logic instr_ready, done, err;
    logic [DW-1:0] in_val;
    logic [3:0] stack_action;
    logic [2:0] alu_code;
    logic [AW-1:0] depth;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    stack_op_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .imm(imm), .top(top), .alu_result(alu_result),
        .in_val(in_val), .stack_action(stack_action), .alu_code(alu_code),
        .depth(depth), .done(done), .err(err), .err_code(err_code)
    );

    // Expected per-cycle outputs, scheduled at acceptance into a small ring indexed by cycle.
    int s_act[8], s_kind[8], s_code[8], s_cap[8], s_acode[8];
    bit s_done[8], s_err[8], s_aseq[8];
    logic [DW-1:0] s_lit[8];
    logic [DW-1:0] stk[$];
    logic [DW-1:0] res;
    int t, free_at, ecode, acode, n_cmp, n_bad;
    bit halted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_f(input int c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (c)
            0: return b + a;
            1: return b - a;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            default: return a * b;
        endcase
    endfunction

    task automatic clear_slot(input int i);
        s_act[i] = 0; s_kind[i] = 0; s_code[i] = 0; s_cap[i] = 0; s_acode[i] = 0;
        s_done[i] = 0; s_err[i] = 0; s_aseq[i] = 0; s_lit[i] = '0;
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) clear_slot(i);
        stk.delete();
        res = '0; free_at = 0; ecode = 0; acode = 0; halted = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model, move to #1 after the next edge.
    task automatic step(input bit r, input bit v, input logic [3:0] op, input logic [DW-1:0] im);
        int s, sz, e, code, n;
        logic [DW-1:0] val;
        bit rdy;
        s = t % 8;
        sz = stk.size();
        rst = r; instr_valid = v; opcode = op; imm = im;
        top = sz > 0 ? stk[sz-1] : '0;
        alu_result = sz > 1 ? alu_f(acode, stk[sz-1], stk[sz-2]) : '0;
        if (s_err[s]) ecode = s_code[s];
        if (s_cap[s] == 1) res = alu_result;
        else if (s_cap[s] == 2) res = top;
        val = s_kind[s] == 2 ? res : s_lit[s];
        rdy = !halted && t >= free_at;
        check("instr_ready", 32'(instr_ready), 32'(rdy));
        check("stack_action", 32'(stack_action), s_act[s]);
        check("depth", 32'(depth), sz);
        check("done", 32'(done), 32'(s_done[s]));
        check("err", 32'(err), 32'(s_err[s]));
        check("err_code", 32'(err_code), ecode);
        if (s_act[s] == 1) check("in_val", 32'(in_val), 32'(val));
        if (s_aseq[s]) check("alu_code", 32'(alu_code), s_acode[s]);
        if (!r && v && rdy) begin
            e = sz + int'(s_act[s] == 1) - int'(s_act[s] == 2);
            n = (t + 1) % 8;
            if (op > 4) code = 3;
            else if (((op == 2 || op == 4) && e < 1) || (op == 3 && e < 2)) code = 1;
            else if ((op == 1 || op == 4) && e >= DEPTH) code = 2;
            else code = 0;
            if (code != 0) begin
                s_err[n] = 1; s_code[n] = code;
`ifdef STACK_SEQ_STICKY_ERR_EN
                halted = 1;
`endif
            end else begin
                case (op)
                    0: s_done[n] = 1;
                    1: begin s_act[n] = 1; s_kind[n] = 1; s_lit[n] = im; s_done[n] = 1; end
                    2: begin s_act[n] = 2; s_done[n] = 1; end
                    3: begin
                        acode = int'(im[2:0]);
                        s_cap[n] = 1;
                        s_act[(t+2)%8] = 2; s_act[(t+3)%8] = 2;
                        s_act[(t+4)%8] = 1; s_kind[(t+4)%8] = 2; s_done[(t+4)%8] = 1;
                        for (int k = 1; k <= 4; k++) begin s_aseq[(t+k)%8] = 1; s_acode[(t+k)%8] = acode; end
                        free_at = t + 4;
                    end
                    default: begin
                        s_cap[n] = 2;
                        s_act[(t+2)%8] = 1; s_kind[(t+2)%8] = 2; s_done[(t+2)%8] = 1;
                        free_at = t + 2;
                    end
                endcase
            end
        end
        if (r) reset_model();
        else begin
            if (s_act[s] == 1) stk.push_back(val);
            else if (s_act[s] == 2) void'(stk.pop_back());
            clear_slot(s);
        end
        @(posedge clk); #1;
        t++;
    endtask

    task automatic issue(input logic [3:0] op, input logic [DW-1:0] im);
        for (int i = 0; i < 8 && (halted || t < free_at); i++) step(0, 0, op, im);
        step(0, 1, op, im);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 4'($urandom), DW'($urandom));
    endtask

    task automatic do_reset();
        step(1, 0, 4'd0, '0);
    endtask

    initial begin
        int x;
        logic [3:0] op;
        bit r;
        n_cmp = 0; n_bad = 0; t = 0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_val", 32'(in_val), 0);
        check("rst_alu_code", 32'(alu_code), 0);
        // push 5, push 7, then add -> 12
        issue(1, 16'd5); issue(1, 16'd7); idle(2);
        issue(3, 16'd0); idle(5);
        // underflow: POP at 0, ALU at 1
        do_reset(); issue(2, '0); idle(2);
        do_reset(); issue(1, 16'd1); issue(3, 16'd0); idle(2);
        // overflow: fill, then PUSHI and DUP
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue(1, DW'(i + 100));
        issue(1, 16'd99); issue(4, '0); idle(3);
        // illegal opcode then PUSHI
        do_reset(); issue(4'd9, '0); issue(1, 16'd1); idle(3);
        // reset during ALU_POP1
        do_reset(); issue(1, 16'd3); issue(1, 16'd4); issue(3, 16'd1);
        step(0, 0, 4'd0, '0);
        step(1, 0, 4'd0, '0);
        idle(3);
        // randomized, alternating push-heavy and pop-heavy phases
        for (int c = 0; c < 3000; c++) begin
            x = $urandom_range(0, 99);
            if ((c / 300) % 2 == 0)
                op = x < 5 ? 4'd0 : x < 50 ? 4'd1 : x < 62 ? 4'd2 : x < 78 ? 4'd3 : x < 95 ? 4'd4 : 4'($urandom_range(5, 15));
            else
                op = x < 5 ? 4'd0 : x < 25 ? 4'd1 : x < 50 ? 4'd2 : x < 75 ? 4'd3 : x < 90 ? 4'd4 : 4'($urandom_range(5, 15));
            r = $urandom_range(0, 299) == 0 || (halted && $urandom_range(0, 3) == 0);
            step(r, $urandom_range(0, 9) < 7, op, DW'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
